tl_tag_tracker: RTL and testbench
=================================

Name: tl_tag_tracker

Overview:
- Next-generation non-posted request tracker for the transaction layer; replaces the FIFO-based tag table.
- Allocates tags for MemRd/CfgRd and stores per-tag request context.
- Tracks split completions by remaining DW count and advances the lower address for each completion.
- Retires tags on the final completion, on error, or on completion timeout; timeouts are found by a background scanner.

Parameters:
- TAG_W, 8, tag width.
- NUM_TAGS, 256, tracked tags; legal range 2..2^TAG_W.
- TS_W, 20, timestamp counter width.
- TIMEOUT_CYC, 50000, completion timeout in clk cycles; must be < 2^TS_W - NUM_TAGS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous invalidate of all tags.
- to_en_i  in  1  timeout checking enable.
- alloc_req_i  in  1  allocation request.
- alloc_gnt_o  out  1  a free tag exists; allocation happens when alloc_req_i && alloc_gnt_o.
- alloc_tag_o  out  TAG_W  lowest-index free tag.
- alloc_req_id_i  in  16  requester ID.
- alloc_addr_i  in  32  request address.
- alloc_len_i  in  10  length in DW; 0 means 1024.
- alloc_attr_i  in  3  attributes.
- cpl_valid_i  in  1  completion header valid.
- cpl_ready_o  out  1  completion accept.
- cpl_tag_i  in  TAG_W  completion tag.
- cpl_dw_i  in  11  payload DW in this completion.
- cpl_status_i  in  3  completion status; 0 = SC.
- rsp_valid_o  out  1  lookup result valid.
- rsp_ready_i  in  1  lookup result accept.
- rsp_tag_o  out  TAG_W  tag of the result.
- rsp_req_id_o  out  16  requester ID.
- rsp_addr_o  out  32  address this completion's data belongs to.
- rsp_attr_o  out  3  attributes.
- rsp_last_o  out  1  tag retired by this completion.
- rsp_err_o  out  2  0 OK, 1 unexpected tag, 2 overflow, 3 bad status.
- to_valid_o  out  1  one-cycle timeout pulse.
- to_tag_o  out  TAG_W  timed-out tag.
- outstanding_o  out  TAG_W+1  count of valid tags.

Behaviour:
- Reset and flush: all tags invalid; outstanding_o=0; alloc_gnt_o=1; alloc_tag_o=0; rsp_valid_o=0; to_valid_o=0; scanner pointer=0; timestamp=0. All rsp_*/to_tag_o outputs reset to 0. Flush also drops a pending response.
- Free set is a valid bitmap. alloc_tag_o is the lowest-index invalid tag (combinational). alloc_gnt_o=0 when all NUM_TAGS are valid.
- On allocation, store req_id, addr, attr, rem_dw (len, with 0→1024) and the current timestamp; the tag becomes valid next cycle.
- A tag retired in cycle N is allocatable in cycle N+1, never in N.
- Completion handshake: cpl_ready_o = !rsp_valid_o || rsp_ready_i. Acceptance occurs when cpl_valid_i && cpl_ready_o.
- On an accepted completion, context is updated in the accept cycle. The response registers load in the same edge (1-cycle latency) and are held until rsp_ready_i.
- Completion cases:
  - Tag invalid: err=1, last=0, context fields 0, no state change.
  - Status≠0: err=3, last=1, tag retired.
  - cpl_dw_i > rem_dw: err=2, last=1, tag retired.
  - Otherwise: err=0; rsp_addr_o = stored addr (pre-increment); stored addr += cpl_dw_i*4 (mod 2^32); rem_dw -= cpl_dw_i. When the new rem_dw==0, last=1 and the tag is retired.
- Back-to-back completions on the same tag see the updated context.
- Timestamp: TS_W-bit free-running counter that wraps.
- Scanner: visits one tag per cycle, incrementing modulo NUM_TAGS. When to_en_i=1, the tag is valid, and (ts - stamp) mod 2^TS_W >= TIMEOUT_CYC, the tag is retired and to_valid_o/to_tag_o pulse the next cycle.
- Timeout detection latency is TIMEOUT_CYC .. TIMEOUT_CYC+NUM_TAGS cycles after allocation.
- Scanner collision: if the scanned tag equals a tag being accepted as a completion in the same cycle, the completion wins and the scanner skips that tag without timing out.
- outstanding_o: +1 per allocation, -1 per retirement; a simultaneous allocation and retirement leaves it unchanged.
- At most one completion retirement and one timeout retirement per cycle (different tags by the collision rule); −2 when both occur.

Test Plan:
- NUM_TAGS=4: 4 allocations → tags 0,1,2,3; alloc_gnt_o=0; outstanding_o=4. Complete tag 2 (len 1, dw 1) → next cycle alloc_tag_o=2.
- Alloc tag 0 with len=8, addr=0x1000. Completions with dw 3, 3, 2 → rsp_addr_o 0x1000, 0x100C, 0x1018; rsp_last_o 0, 0, 1; tag free afterwards.
- Completion on an unallocated tag 5 → rsp_err_o=1, rsp_last_o=0, outstanding_o unchanged. Alloc len=2 then completion dw=4 → err=2, last=1, tag freed.
- Hold rsp_ready_i=0 with two completions queued → cpl_ready_o=0 after the first; the second is accepted the cycle rsp_ready_i=1; the first response is stable while held.
- TIMEOUT_CYC=20, NUM_TAGS=4: alloc tag 0, no completion → to_valid_o pulses with to_tag_o=0 between cycle 20 and 24. A later completion on tag 0 → err=1. With to_en_i=0, no pulse.
- Assert rst_n low mid split-completion, or flush_i → all outputs at reset values; outstanding_o=0; alloc_tag_o=0.

Source files
------------

// File: rtl/tl_tag_tracker.sv
// Non-posted request tag tracker: allocates tags, holds per-tag request context,
// walks split completions and retires tags on last completion, error or timeout.
module tl_tag_tracker #(
    parameter int TAG_W       = 8,
    parameter int NUM_TAGS    = 256,
    parameter int TS_W        = 20,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             to_en_i,
    input  logic             alloc_req_i,
    output logic             alloc_gnt_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic [15:0]      alloc_req_id_i,
    input  logic [31:0]      alloc_addr_i,
    input  logic [9:0]       alloc_len_i,
    input  logic [2:0]       alloc_attr_i,
    input  logic             cpl_valid_i,
    output logic             cpl_ready_o,
    input  logic [TAG_W-1:0] cpl_tag_i,
    input  logic [10:0]      cpl_dw_i,
    input  logic [2:0]       cpl_status_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [15:0]      rsp_req_id_o,
    output logic [31:0]      rsp_addr_o,
    output logic [2:0]       rsp_attr_o,
    output logic             rsp_last_o,
    output logic [1:0]       rsp_err_o,
    output logic             to_valid_o,
    output logic [TAG_W-1:0] to_tag_o,
    output logic [TAG_W:0]   outstanding_o
);

    localparam int IDX_W = $clog2(NUM_TAGS);
    localparam logic [TAG_W:0]  NUM_TAGS_L = (TAG_W+1)'(NUM_TAGS);
    localparam logic [TS_W-1:0] TIMEOUT_L  = TS_W'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TAGS - 1);

    // Per-tag context; only the valid bitmap needs a reset.
    logic [31:0]     addr_mem   [NUM_TAGS];
    logic [10:0]     rem_mem    [NUM_TAGS];
    logic [15:0]     req_id_mem [NUM_TAGS];
    logic [2:0]      attr_mem   [NUM_TAGS];
    logic [TS_W-1:0] stamp_mem  [NUM_TAGS];

    logic [NUM_TAGS-1:0] valid_reg, valid_next;
    logic [TAG_W:0]      count_reg;
    logic [TS_W-1:0]     ts_reg;
    logic [IDX_W-1:0]    scan_ptr_reg;

    logic             rsp_valid_reg;
    logic [TAG_W-1:0] rsp_tag_reg;
    logic [15:0]      rsp_req_id_reg;
    logic [31:0]      rsp_addr_reg;
    logic [2:0]       rsp_attr_reg;
    logic             rsp_last_reg;
    logic [1:0]       rsp_err_reg;
    logic             to_valid_reg;
    logic [TAG_W-1:0] to_tag_reg;

    // Allocation: lowest-index free tag
    logic             alloc_found;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_fire;
    logic [10:0]      alloc_rem;

    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    assign alloc_fire = alloc_req_i && alloc_found;
    assign alloc_rem  = (alloc_len_i == 10'd0) ? 11'd1024 : {1'b0, alloc_len_i};

    // Completion lookup and context update
    logic             cpl_accept;
    logic             cpl_in_range;
    logic [IDX_W-1:0] cpl_idx;
    logic             cpl_hit;
    logic [10:0]      cur_rem;
    logic [31:0]      cur_addr;
    logic [10:0]      new_rem;
    logic [31:0]      new_addr;
    logic [1:0]       err_next;
    logic             last_next;
    logic [31:0]      rsp_addr_next;
    logic [15:0]      rsp_req_id_next;
    logic [2:0]       rsp_attr_next;
    logic             cpl_upd;
    logic             cpl_retire;
    logic             cpl_upd_fire;

    assign cpl_ready_o  = !rsp_valid_reg || rsp_ready_i;
    assign cpl_accept   = cpl_valid_i && cpl_ready_o;
    assign cpl_in_range = {1'b0, cpl_tag_i} < NUM_TAGS_L;
    assign cpl_idx      = cpl_tag_i[IDX_W-1:0];
    assign cpl_hit      = cpl_in_range && valid_reg[cpl_idx];
    assign cur_rem      = rem_mem[cpl_idx];
    assign cur_addr     = addr_mem[cpl_idx];
    assign new_rem      = cur_rem - cpl_dw_i;
    assign new_addr     = cur_addr + {19'd0, cpl_dw_i, 2'b00};

    always_comb begin
        err_next        = 2'd0;
        last_next       = 1'b0;
        rsp_addr_next   = '0;
        rsp_req_id_next = '0;
        rsp_attr_next   = '0;
        cpl_upd         = 1'b0;
        if (!cpl_hit) begin
            err_next = 2'd1;
        end else begin
            rsp_addr_next   = cur_addr;
            rsp_req_id_next = req_id_mem[cpl_idx];
            rsp_attr_next   = attr_mem[cpl_idx];
            if (cpl_status_i != 3'd0) begin
                err_next  = 2'd3;
                last_next = 1'b1;
            end else if (cpl_dw_i > cur_rem) begin
                err_next  = 2'd2;
                last_next = 1'b1;
            end else begin
                last_next = (new_rem == 11'd0);
                cpl_upd   = (new_rem != 11'd0);
            end
        end
    end

    assign cpl_retire   = cpl_accept && cpl_hit && last_next;
    assign cpl_upd_fire = cpl_accept && cpl_upd;

    // Background timeout scanner; a same-cycle completion on the scanned tag wins.
    logic [TS_W-1:0] scan_age;
    logic            scan_collide;
    logic            to_retire;

    assign scan_age     = ts_reg - stamp_mem[scan_ptr_reg];
    assign scan_collide = cpl_accept && cpl_in_range && (cpl_idx == scan_ptr_reg);
    assign to_retire    = to_en_i && valid_reg[scan_ptr_reg] &&
                          (scan_age >= TIMEOUT_L) && !scan_collide;

    for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_valid
        assign valid_next[gi] =
            (valid_reg[gi] &&
             !(cpl_retire && (cpl_idx == IDX_W'(gi))) &&
             !(to_retire && (scan_ptr_reg == IDX_W'(gi)))) ||
            (alloc_fire && (alloc_idx == IDX_W'(gi)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg      <= '0;
            count_reg      <= '0;
            ts_reg         <= '0;
            scan_ptr_reg   <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_tag_reg    <= '0;
            rsp_req_id_reg <= '0;
            rsp_addr_reg   <= '0;
            rsp_attr_reg   <= '0;
            rsp_last_reg   <= 1'b0;
            rsp_err_reg    <= '0;
            to_valid_reg   <= 1'b0;
            to_tag_reg     <= '0;
        end else if (flush_i) begin
            // Flush overrides any handshake in the same cycle.
            valid_reg      <= '0;
            count_reg      <= '0;
            ts_reg         <= '0;
            scan_ptr_reg   <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_tag_reg    <= '0;
            rsp_req_id_reg <= '0;
            rsp_addr_reg   <= '0;
            rsp_attr_reg   <= '0;
            rsp_last_reg   <= 1'b0;
            rsp_err_reg    <= '0;
            to_valid_reg   <= 1'b0;
            to_tag_reg     <= '0;
        end else begin
            valid_reg    <= valid_next;
            count_reg    <= count_reg + (TAG_W+1)'(alloc_fire)
                                      - (TAG_W+1)'(cpl_retire)
                                      - (TAG_W+1)'(to_retire);
            ts_reg       <= ts_reg + 1'b1;
            scan_ptr_reg <= (scan_ptr_reg == LAST_IDX) ? '0 : scan_ptr_reg + 1'b1;
            if (cpl_accept) begin
                rsp_valid_reg  <= 1'b1;
                rsp_tag_reg    <= cpl_tag_i;
                rsp_req_id_reg <= rsp_req_id_next;
                rsp_addr_reg   <= rsp_addr_next;
                rsp_attr_reg   <= rsp_attr_next;
                rsp_last_reg   <= last_next;
                rsp_err_reg    <= err_next;
            end else if (rsp_ready_i) begin
                rsp_valid_reg <= 1'b0;
            end
            to_valid_reg <= to_retire;
            if (to_retire) begin
                to_tag_reg <= TAG_W'(scan_ptr_reg);
            end
        end
    end

    // Allocation and completion never target the same tag (free vs. valid).
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            addr_mem[alloc_idx]   <= alloc_addr_i;
            rem_mem[alloc_idx]    <= alloc_rem;
            req_id_mem[alloc_idx] <= alloc_req_id_i;
            attr_mem[alloc_idx]   <= alloc_attr_i;
            stamp_mem[alloc_idx]  <= ts_reg;
        end
        if (cpl_upd_fire) begin
            addr_mem[cpl_idx] <= new_addr;
            rem_mem[cpl_idx]  <= new_rem;
        end
    end

    assign alloc_gnt_o   = alloc_found;
    assign alloc_tag_o   = TAG_W'(alloc_idx);
    assign rsp_valid_o   = rsp_valid_reg;
    assign rsp_tag_o     = rsp_tag_reg;
    assign rsp_req_id_o  = rsp_req_id_reg;
    assign rsp_addr_o    = rsp_addr_reg;
    assign rsp_attr_o    = rsp_attr_reg;
    assign rsp_last_o    = rsp_last_reg;
    assign rsp_err_o     = rsp_err_reg;
    assign to_valid_o    = to_valid_reg;
    assign to_tag_o      = to_tag_reg;
    assign outstanding_o = count_reg;

endmodule

// File: tb/tb_tl_tag_tracker.sv
// Directed bench for tl_tag_tracker with a small configuration (4 tags, 20-cycle timeout).
module tb_tl_tag_tracker;

    localparam int TAG_W       = 3;
    localparam int NUM_TAGS    = 4;
    localparam int TS_W        = 8;
    localparam int TIMEOUT_CYC = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i;
    logic             to_en_i;
    logic             alloc_req_i;
    logic             alloc_gnt_o;
    logic [TAG_W-1:0] alloc_tag_o;
    logic [15:0]      alloc_req_id_i;
    logic [31:0]      alloc_addr_i;
    logic [9:0]       alloc_len_i;
    logic [2:0]       alloc_attr_i;
    logic             cpl_valid_i;
    logic             cpl_ready_o;
    logic [TAG_W-1:0] cpl_tag_i;
    logic [10:0]      cpl_dw_i;
    logic [2:0]       cpl_status_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [15:0]      rsp_req_id_o;
    logic [31:0]      rsp_addr_o;
    logic [2:0]       rsp_attr_o;
    logic             rsp_last_o;
    logic [1:0]       rsp_err_o;
    logic             to_valid_o;
    logic [TAG_W-1:0] to_tag_o;
    logic [TAG_W:0]   outstanding_o;

    int errors = 0;
    int checks = 0;

    tl_tag_tracker #(
        .TAG_W(TAG_W), .NUM_TAGS(NUM_TAGS), .TS_W(TS_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .to_en_i(to_en_i),
        .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_tag_o(alloc_tag_o),
        .alloc_req_id_i(alloc_req_id_i), .alloc_addr_i(alloc_addr_i),
        .alloc_len_i(alloc_len_i), .alloc_attr_i(alloc_attr_i),
        .cpl_valid_i(cpl_valid_i), .cpl_ready_o(cpl_ready_o), .cpl_tag_i(cpl_tag_i),
        .cpl_dw_i(cpl_dw_i), .cpl_status_i(cpl_status_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_tag_o(rsp_tag_o),
        .rsp_req_id_o(rsp_req_id_o), .rsp_addr_o(rsp_addr_o), .rsp_attr_o(rsp_attr_o),
        .rsp_last_o(rsp_last_o), .rsp_err_o(rsp_err_o),
        .to_valid_o(to_valid_o), .to_tag_o(to_tag_o), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input int id, input int addr, input int len, input int attr,
                            input int exp_tag);
        alloc_req_id_i = 16'(id);
        alloc_addr_i   = 32'(addr);
        alloc_len_i    = 10'(len);
        alloc_attr_i   = 3'(attr);
        alloc_req_i    = 1'b1;
        #1;
        chk("alloc_gnt", 32'(alloc_gnt_o), 1);
        chk("alloc_tag", 32'(alloc_tag_o), 32'(exp_tag));
        $display("alloc tag=%0d addr=0x%0h len=%0d", alloc_tag_o, alloc_addr_i, alloc_len_i);
        tick();
        alloc_req_i = 1'b0;
    endtask

    task automatic do_cpl(input int tag, input int dw, input int status);
        cpl_tag_i    = TAG_W'(tag);
        cpl_dw_i     = 11'(dw);
        cpl_status_i = 3'(status);
        cpl_valid_i  = 1'b1;
        tick();
        cpl_valid_i  = 1'b0;
        $display("cpl tag=%0d dw=%0d st=%0d -> rsp addr=0x%0h last=%0d err=%0d",
                 tag, dw, status, rsp_addr_o, rsp_last_o, rsp_err_o);
    endtask

    task automatic chk_rsp(input string name, input int tag, input int addr,
                           input int last, input int err);
        chk({name, ".valid"}, 32'(rsp_valid_o), 1);
        chk({name, ".tag"},   32'(rsp_tag_o),   32'(tag));
        chk({name, ".addr"},  rsp_addr_o,       32'(addr));
        chk({name, ".last"},  32'(rsp_last_o),  32'(last));
        chk({name, ".err"},   32'(rsp_err_o),   32'(err));
    endtask

    initial begin
        int seen;
        int pulses;
        logic [TAG_W-1:0] tt;

        rst_n = 1'b0; flush_i = 1'b0; to_en_i = 1'b0; alloc_req_i = 1'b0;
        alloc_req_id_i = '0; alloc_addr_i = '0; alloc_len_i = '0; alloc_attr_i = '0;
        cpl_valid_i = 1'b0; cpl_tag_i = '0; cpl_dw_i = '0; cpl_status_i = '0;
        rsp_ready_i = 1'b1;

        // Reset state
        tick();
        chk("rst.outstanding", 32'(outstanding_o), 0);
        chk("rst.gnt",         32'(alloc_gnt_o),   1);
        chk("rst.alloc_tag",   32'(alloc_tag_o),   0);
        chk("rst.rsp_valid",   32'(rsp_valid_o),   0);
        chk("rst.to_valid",    32'(to_valid_o),    0);
        chk("rst.cpl_ready",   32'(cpl_ready_o),   1);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill all tags, then free tag 2
        for (int i = 0; i < NUM_TAGS; i++) do_alloc(16'h0100 + i, i * 256, 1, 0, i);
        chk("full.gnt",         32'(alloc_gnt_o),   0);
        chk("full.outstanding", 32'(outstanding_o), 4);
        do_cpl(2, 1, 0);
        chk_rsp("free2", 2, 32'h200, 1, 0);
        chk("free2.req_id",      32'(rsp_req_id_o),  32'h0102);
        chk("free2.alloc_tag",   32'(alloc_tag_o),   2);
        chk("free2.gnt",         32'(alloc_gnt_o),   1);
        chk("free2.outstanding", 32'(outstanding_o), 3);
        do_cpl(0, 1, 0);
        do_cpl(1, 1, 0);
        do_cpl(3, 1, 0);
        chk_rsp("free3", 3, 32'h300, 1, 0);
        chk("drain.outstanding", 32'(outstanding_o), 0);
        tick();
        chk("drain.rsp_valid", 32'(rsp_valid_o), 0);

        // Split completions, back to back
        do_alloc(16'h1234, 32'h1000, 8, 2, 0);
        do_cpl(0, 3, 0);
        chk_rsp("split1", 0, 32'h1000, 0, 0);
        chk("split1.req_id", 32'(rsp_req_id_o), 32'h1234);
        chk("split1.attr",   32'(rsp_attr_o),   2);
        do_cpl(0, 3, 0);
        chk_rsp("split2", 0, 32'h100C, 0, 0);
        do_cpl(0, 2, 0);
        chk_rsp("split3", 0, 32'h1018, 1, 0);
        chk("split.outstanding", 32'(outstanding_o), 0);
        chk("split.alloc_tag",   32'(alloc_tag_o),   0);

        // Error cases
        do_cpl(5, 1, 0);
        chk_rsp("unexp5", 5, 0, 0, 1);
        chk("unexp5.req_id",      32'(rsp_req_id_o),  0);
        chk("unexp5.outstanding", 32'(outstanding_o), 0);
        do_cpl(3, 1, 0);
        chk_rsp("unexp3", 3, 0, 0, 1);
        do_alloc(16'hABCD, 32'h3000, 2, 5, 0);
        do_cpl(0, 4, 0);
        chk_rsp("ovf", 0, 32'h3000, 1, 2);
        chk("ovf.req_id",      32'(rsp_req_id_o),  32'hABCD);
        chk("ovf.attr",        32'(rsp_attr_o),    5);
        chk("ovf.outstanding", 32'(outstanding_o), 0);
        do_alloc(16'h0042, 32'h4000, 4, 1, 0);
        do_cpl(0, 1, 4);
        chk_rsp("badst", 0, 32'h4000, 1, 3);
        chk("badst.outstanding", 32'(outstanding_o), 0);

        // Length 0 means 1024 DW
        do_alloc(16'h0007, 32'hFFFF_F000, 0, 0, 0);
        do_cpl(0, 1023, 0);
        chk_rsp("len0a", 0, 32'hFFFF_F000, 0, 0);
        do_cpl(0, 1, 0);
        chk_rsp("len0b", 0, 32'hFFFF_FFFC, 1, 0);
        chk("len0.outstanding", 32'(outstanding_o), 0);

        // Response backpressure
        do_alloc(16'h0055, 32'h2000, 4, 0, 0);
        rsp_ready_i = 1'b0;
        cpl_tag_i = '0; cpl_dw_i = 11'd1; cpl_status_i = '0; cpl_valid_i = 1'b1;
        tick();
        chk_rsp("bp.first", 0, 32'h2000, 0, 0);
        chk("bp.cpl_ready0", 32'(cpl_ready_o), 0);
        tick();
        tick();
        chk_rsp("bp.held", 0, 32'h2000, 0, 0);
        chk("bp.cpl_ready1", 32'(cpl_ready_o), 0);
        rsp_ready_i = 1'b1;
        #1;
        chk("bp.cpl_ready2", 32'(cpl_ready_o), 1);
        tick();
        cpl_valid_i = 1'b0;
        chk_rsp("bp.second", 0, 32'h2004, 0, 0);
        chk("bp.outstanding", 32'(outstanding_o), 1);
        tick();
        chk("bp.rsp_drop", 32'(rsp_valid_o), 0);

        // Flush with a pending response
        rsp_ready_i = 1'b0;
        do_cpl(0, 1, 0);
        chk_rsp("pre_flush", 0, 32'h2008, 0, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush.rsp_valid",   32'(rsp_valid_o),   0);
        chk("flush.rsp_addr",    rsp_addr_o,         0);
        chk("flush.outstanding", 32'(outstanding_o), 0);
        chk("flush.alloc_tag",   32'(alloc_tag_o),   0);
        chk("flush.gnt",         32'(alloc_gnt_o),   1);
        rsp_ready_i = 1'b1;
        do_cpl(0, 1, 0);
        chk_rsp("post_flush", 0, 0, 0, 1);

        // Timeout on tag 1 while tag 0 completes normally
        to_en_i = 1'b1;
        do_alloc(16'h0001, 32'h5000, 1, 0, 0);
        do_alloc(16'h0002, 32'h6000, 4, 0, 1);
        seen = 0; pulses = 0; tt = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) begin
                cpl_tag_i = '0; cpl_dw_i = 11'd1; cpl_status_i = '0; cpl_valid_i = 1'b1;
            end
            tick();
            cpl_valid_i = 1'b0;
            if (to_valid_o) begin
                pulses++;
                if (seen == 0) begin
                    seen = k;
                    tt   = to_tag_o;
                end
            end
        end
        $display("timeout pulse at cycle %0d tag=%0d pulses=%0d", seen, tt, pulses);
        chk("to.window", 32'((seen >= TIMEOUT_CYC) && (seen <= TIMEOUT_CYC + NUM_TAGS)), 1);
        chk("to.tag",         32'(tt),            1);
        chk("to.pulses",      32'(pulses),        1);
        chk("to.outstanding", 32'(outstanding_o), 0);
        do_cpl(1, 1, 0);
        chk_rsp("to.late_cpl", 1, 0, 0, 1);

        // No timeout when disabled
        to_en_i = 1'b0;
        do_alloc(16'h0003, 32'h7000, 4, 0, 0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (to_valid_o) pulses++;
        end
        chk("to_off.pulses",      32'(pulses),        0);
        chk("to_off.outstanding", 32'(outstanding_o), 1);

        // Asynchronous reset in the middle of a split completion
        do_cpl(0, 1, 0);
        chk_rsp("pre_rst", 0, 32'h7000, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.rsp_valid",   32'(rsp_valid_o),   0);
        chk("arst.rsp_addr",    rsp_addr_o,         0);
        chk("arst.outstanding", 32'(outstanding_o), 0);
        chk("arst.alloc_tag",   32'(alloc_tag_o),   0);
        chk("arst.gnt",         32'(alloc_gnt_o),   1);
        tick();
        rst_n = 1'b1;
        tick();
        do_cpl(0, 1, 0);
        chk_rsp("post_rst", 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
